// File: rtl/lag_pl_status_tracker.sv
// ============================================================================
// Module  : lag_pl_status_tracker
// Brief   : Per output-PL ownership state (FREE/ACTIVE/DRAIN) and downstream
//           credit bookkeeping feeding the LAG router PL allocator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lag_pl_status_tracker #(
  parameter int np           = 5,
  parameter int nv           = 4,
  parameter int buf_len      = 4,
  parameter int free_on_tail = 0,
  localparam int N           = np * nv,
  localparam int CW          = $clog2(buf_len + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    pl_allocated,
  input  logic [N-1:0]    flit_sent,
  input  logic [N-1:0]    flit_tail,
  input  logic [N-1:0]    credit_in,
  output logic [N-1:0]    pl_alloc_status,
  output logic [N-1:0]    credit_avail,
  output logic [N*CW-1:0] credit_count,
  output logic            error
);

  localparam logic [CW-1:0] c_BUF_LEN = CW'(buf_len);

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  logic [N-1:0] w_lane_err;
  logic         r_error;

  for (genvar i = 0; i < N; i++) begin : g_lane
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_send_ok;
    logic          w_cred_ok;
    logic          w_err;

    // A credit in the same cycle makes a send at cnt=0 legal, and a valid
    // send makes a credit at cnt=buf_len legal; each protects the other.
    always_comb begin
      w_send_ok   = flit_sent[i] && (r_state == ST_ACTIVE) &&
                    ((r_cnt != '0) || credit_in[i]);
      w_cred_ok   = credit_in[i] && ((r_cnt != c_BUF_LEN) || w_send_ok);
      w_err       = (pl_allocated[i] && (r_state != ST_FREE)) ||
                    (flit_sent[i] && !w_send_ok) ||
                    (credit_in[i] && !w_cred_ok);
      w_cnt_nxt   = r_cnt - CW'(w_send_ok) + CW'(w_cred_ok);
      w_state_nxt = r_state;
      case (r_state)
        ST_FREE: begin
          if (pl_allocated[i]) w_state_nxt = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (w_send_ok && flit_tail[i])
            w_state_nxt = (free_on_tail != 0) ? ST_FREE : ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_cnt_nxt == c_BUF_LEN) w_state_nxt = ST_FREE;
        end
        default: w_state_nxt = ST_FREE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= ST_FREE;
        r_cnt   <= c_BUF_LEN;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end

    assign w_lane_err[i]              = w_err;
    assign pl_alloc_status[i]         = (r_state == ST_FREE);
    assign credit_avail[i]            = (r_cnt != '0);
    assign credit_count[i*CW +: CW]   = r_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_error <= 1'b0;
    end else if (|w_lane_err) begin
      r_error <= 1'b1;
    end
  end

  assign error = r_error;

endmodule

`default_nettype wire

// File: tb/tb_lag_pl_status_tracker.sv
// ============================================================================
// Module  : tb_lag_pl_status_tracker
// Brief   : Directed table-driven bench; DUT A releases on credits, DUT B on tail.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lag_pl_status_tracker;

  localparam int NP = 5;
  localparam int NV = 4;
  localparam int N  = NP * NV;
  localparam int CW = 3;

  localparam logic [19:0] ALL = 20'hFFFFF;
  localparam logic [19:0] L0  = 20'h00001;
  localparam logic [19:0] L3  = 20'h00008;
  localparam logic [19:0] L6  = 20'h00040;
  localparam logic [19:0] Z   = 20'h00000;
  localparam logic [19:0] NS0 = 20'hFFFFE;
  localparam logic [19:0] NS6 = 20'hFFFBF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           a_rst, b_rst;
  logic [N-1:0]   a_alloc, a_sent, a_tail, a_cred;
  logic [N-1:0]   b_alloc, b_sent, b_tail, b_cred;
  logic [N-1:0]   a_stat, a_avail, b_stat, b_avail;
  logic [N*CW-1:0] a_cc, b_cc;
  logic           a_err, b_err;

  lag_pl_status_tracker #(.np(NP), .nv(NV), .buf_len(4), .free_on_tail(0)) u_a (
    .clk(clk), .rst(a_rst), .pl_allocated(a_alloc), .flit_sent(a_sent),
    .flit_tail(a_tail), .credit_in(a_cred), .pl_alloc_status(a_stat),
    .credit_avail(a_avail), .credit_count(a_cc), .error(a_err)
  );

  lag_pl_status_tracker #(.np(NP), .nv(NV), .buf_len(4), .free_on_tail(1)) u_b (
    .clk(clk), .rst(b_rst), .pl_allocated(b_alloc), .flit_sent(b_sent),
    .flit_tail(b_tail), .credit_in(b_cred), .pl_alloc_status(b_stat),
    .credit_avail(b_avail), .credit_count(b_cc), .error(b_err)
  );

  typedef struct {
    logic        rst;
    logic [19:0] alloc, sent, tail, cred;
    logic [19:0] e_stat;
    int          lane;
    logic [2:0]  e_cnt;
    logic        e_avail;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic r, logic [19:0] al, logic [19:0] se,
                              logic [19:0] ta, logic [19:0] cr, logic [19:0] st,
                              int ln, logic [2:0] cn, logic av, logic er);
    vec_t v;
    v.rst = r; v.alloc = al; v.sent = se; v.tail = ta; v.cred = cr;
    v.e_stat = st; v.lane = ln; v.e_cnt = cn; v.e_avail = av; v.e_err = er;
    return v;
  endfunction

  task automatic cmp(string nm, int idx, logic [19:0] act, logic [19:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic check(string tag, int idx, logic [19:0] st, logic [N*CW-1:0] cc,
                       logic [19:0] av, logic er, vec_t v);
    logic [2:0] cnt;
    cnt = cc[v.lane*CW +: CW];
    cmp({tag, " status"}, idx, st, v.e_stat);
    cmp({tag, " count"},  idx, {17'd0, cnt}, {17'd0, v.e_cnt});
    cmp({tag, " avail"},  idx, {19'd0, av[v.lane]}, {19'd0, v.e_avail});
    cmp({tag, " error"},  idx, {19'd0, er}, {19'd0, v.e_err});
  endtask

  task automatic step_a(vec_t v, int idx);
    @(negedge clk);
    a_rst = v.rst; a_alloc = v.alloc; a_sent = v.sent;
    a_tail = v.tail; a_cred = v.cred;
    @(posedge clk);
    #1;
    n_vec++;
    check("A", idx, a_stat, a_cc, a_avail, a_err, v);
  endtask

  task automatic step_b(vec_t v, int idx);
    @(negedge clk);
    b_rst = v.rst; b_alloc = v.alloc; b_sent = v.sent;
    b_tail = v.tail; b_cred = v.cred;
    @(posedge clk);
    #1;
    n_vec++;
    check("B", idx, b_stat, b_cc, b_avail, b_err, v);
  endtask

  initial begin
    a_rst = 1'b1; a_alloc = '0; a_sent = '0; a_tail = '0; a_cred = '0;
    b_rst = 1'b1; b_alloc = '0; b_sent = '0; b_tail = '0; b_cred = '0;

    // Credit-release lane 6 walk-through: grant, 3 sends, drain by credits
    tbl.push_back(mk(1, Z,  Z,  Z,  Z,  ALL, 6, 3'd4, 1, 0));
    tbl.push_back(mk(0, Z,  Z,  Z,  Z,  ALL, 6, 3'd4, 1, 0));
    tbl.push_back(mk(0, Z,  Z,  Z,  Z,  ALL, 6, 3'd4, 1, 0));
    tbl.push_back(mk(0, Z,  Z,  Z,  Z,  ALL, 6, 3'd4, 1, 0));
    tbl.push_back(mk(0, L6, Z,  Z,  Z,  NS6, 6, 3'd4, 1, 0));
    tbl.push_back(mk(0, Z,  L6, Z,  Z,  NS6, 6, 3'd3, 1, 0));
    tbl.push_back(mk(0, Z,  L6, Z,  Z,  NS6, 6, 3'd2, 1, 0));
    tbl.push_back(mk(0, Z,  L6, L6, Z,  NS6, 6, 3'd1, 1, 0));
    tbl.push_back(mk(0, Z,  Z,  Z,  Z,  NS6, 6, 3'd1, 1, 0));
    tbl.push_back(mk(0, Z,  Z,  Z,  L6, NS6, 6, 3'd2, 1, 0));
    tbl.push_back(mk(0, Z,  Z,  Z,  L6, NS6, 6, 3'd3, 1, 0));
    tbl.push_back(mk(0, Z,  Z,  Z,  L6, ALL, 6, 3'd4, 1, 0));
    // Reset mid-packet on lane 0 (count 1), reset wins over a send
    tbl.push_back(mk(0, L0, Z,  Z,  Z,  NS0, 0, 3'd4, 1, 0));
    tbl.push_back(mk(0, Z,  L0, Z,  Z,  NS0, 0, 3'd3, 1, 0));
    tbl.push_back(mk(0, Z,  L0, Z,  Z,  NS0, 0, 3'd2, 1, 0));
    tbl.push_back(mk(0, Z,  L0, Z,  Z,  NS0, 0, 3'd1, 1, 0));
    tbl.push_back(mk(1, Z,  L0, Z,  Z,  ALL, 0, 3'd4, 1, 0));
    // Grant of an ACTIVE lane and overflow credit
    tbl.push_back(mk(0, L0, Z,  Z,  Z,  NS0, 0, 3'd4, 1, 0));
    tbl.push_back(mk(0, L0, Z,  Z,  Z,  NS0, 0, 3'd4, 1, 1));
    tbl.push_back(mk(0, Z,  Z,  Z,  L0, NS0, 0, 3'd4, 1, 1));
    tbl.push_back(mk(0, Z,  Z,  Z,  Z,  NS0, 0, 3'd4, 1, 1));
    tbl.push_back(mk(1, Z,  Z,  Z,  Z,  ALL, 0, 3'd4, 1, 0));
    // Send on a FREE lane
    tbl.push_back(mk(0, Z,  L3, L3, Z,  ALL, 3, 3'd4, 1, 1));
    tbl.push_back(mk(1, Z,  Z,  Z,  Z,  ALL, 0, 3'd4, 1, 0));
    // Send+credit together, then underflow at count 0
    tbl.push_back(mk(0, L0, Z,  Z,  Z,  NS0, 0, 3'd4, 1, 0));
    tbl.push_back(mk(0, Z,  L0, Z,  Z,  NS0, 0, 3'd3, 1, 0));
    tbl.push_back(mk(0, Z,  L0, Z,  Z,  NS0, 0, 3'd2, 1, 0));
    tbl.push_back(mk(0, Z,  L0, Z,  L0, NS0, 0, 3'd2, 1, 0));
    tbl.push_back(mk(0, Z,  L0, Z,  Z,  NS0, 0, 3'd1, 1, 0));
    tbl.push_back(mk(0, Z,  L0, Z,  Z,  NS0, 0, 3'd0, 0, 0));
    tbl.push_back(mk(0, Z,  L0, Z,  Z,  NS0, 0, 3'd0, 0, 1));
    tbl.push_back(mk(0, Z,  Z,  Z,  Z,  NS0, 0, 3'd0, 0, 1));
    tbl.push_back(mk(1, Z,  Z,  Z,  Z,  ALL, 0, 3'd4, 1, 0));
    // Grant on the cycle a draining lane frees is rejected
    tbl.push_back(mk(0, L6, Z,  Z,  Z,  NS6, 6, 3'd4, 1, 0));
    tbl.push_back(mk(0, Z,  L6, L6, Z,  NS6, 6, 3'd3, 1, 0));
    tbl.push_back(mk(0, L6, Z,  Z,  L6, ALL, 6, 3'd4, 1, 1));
    tbl.push_back(mk(0, Z,  Z,  Z,  Z,  ALL, 6, 3'd4, 1, 1));
    // Send during DRAIN is dropped
    tbl.push_back(mk(1, Z,  Z,  Z,  Z,  ALL, 6, 3'd4, 1, 0));
    tbl.push_back(mk(0, L6, Z,  Z,  Z,  NS6, 6, 3'd4, 1, 0));
    tbl.push_back(mk(0, Z,  L6, L6, Z,  NS6, 6, 3'd3, 1, 0));
    tbl.push_back(mk(0, Z,  L6, Z,  Z,  NS6, 6, 3'd3, 1, 1));
    tbl.push_back(mk(0, Z,  Z,  Z,  L6, ALL, 6, 3'd4, 1, 1));

    foreach (tbl[k]) step_a(tbl[k], k);

    // Tail-release DUT: free while credits outstanding, legal re-grant
    step_b(mk(1, Z,  Z,  Z,  Z,  ALL, 6, 3'd4, 1, 0), 100);
    step_b(mk(0, L6, Z,  Z,  Z,  NS6, 6, 3'd4, 1, 0), 101);
    step_b(mk(0, Z,  L6, Z,  Z,  NS6, 6, 3'd3, 1, 0), 102);
    step_b(mk(0, Z,  L6, Z,  Z,  NS6, 6, 3'd2, 1, 0), 103);
    step_b(mk(0, Z,  L6, L6, Z,  ALL, 6, 3'd1, 1, 0), 104);
    step_b(mk(0, L6, Z,  Z,  Z,  NS6, 6, 3'd1, 1, 0), 105);
    step_b(mk(0, Z,  Z,  Z,  L6, NS6, 6, 3'd2, 1, 0), 106);
    step_b(mk(0, Z,  Z,  Z,  L6, NS6, 6, 3'd3, 1, 0), 107);
    step_b(mk(0, Z,  Z,  Z,  L6, NS6, 6, 3'd4, 1, 0), 108);
    step_b(mk(0, Z,  L6, L6, Z,  ALL, 6, 3'd3, 1, 0), 109);
    step_b(mk(0, Z,  Z,  Z,  L6, ALL, 6, 3'd4, 1, 0), 110);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lag_pl_status_tracker.md
# lag_pl_status_tracker

Output-side bookkeeping for physical-lane (PL) allocation in the LAG router. Tracks, per output port and PL, whether the lane is free, owned by a packet, or draining, and keeps the downstream credit count for each lane. Consumes the allocator's per-cycle `pl_allocated` grants plus switch-traversal and credit-return events, and produces the registered `pl_alloc_status` vector the PL allocator uses to choose free lanes.

## Interface

Parameters:
- `np`, 5, number of router ports
- `nv`, 4, PLs per port
- `buf_len`, 4, downstream flit buffer depth per PL, in flits; must be at least 1
- `free_on_tail`, 0, PL release point: 1 releases the lane when the tail flit is sent; 0 releases it when all credits have returned

Ports:
- `clk`, input, 1, sole clock; all state updates on its rising edge
- `rst`, input, 1, reset; synchronous, active-high
- `pl_allocated`, input, np*nv, index p*nv+v; a 1 means the allocator granted output PL v of port p this cycle
- `flit_sent`, input, np*nv, one flit left on output PL
- `flit_tail`, input, np*nv, qualifies `flit_sent`: the flit is a tail flit; ignored when `flit_sent` is 0
- `credit_in`, input, np*nv, one credit returned from downstream for the PL
- `pl_alloc_status`, output, np*nv, 1 means the PL is FREE; registered
- `credit_avail`, output, np*nv, 1 means the credit count is not 0; registered
- `credit_count`, output, np*nv*CW, where CW = $clog2(buf_len+1); per-PL credit count, field index p*nv+v
- `error`, output, 1, sticky protocol-violation flag; cleared only by `rst`

## Operation

- Each PL has an independent 2-bit state, FREE, ACTIVE or DRAIN, and a CW-bit credit counter.
- FREE -> ACTIVE: `pl_allocated` is 1.
- ACTIVE -> DRAIN: `flit_sent` and `flit_tail` are both 1 and `free_on_tail` = 0.
- ACTIVE -> FREE: `flit_sent` and `flit_tail` are both 1 and `free_on_tail` = 1.
- DRAIN -> FREE: the next credit count equals `buf_len`. The count includes any credit arriving in the same cycle.
- A single-flit packet (head is also tail) is a legal tail send from ACTIVE.
- Credit counter update: next = cnt − `flit_sent` + `credit_in`.
  - A simultaneous send and credit leave the count unchanged.
- Error conditions: each sets `error`, and the offending event is dropped for that PL only; other simultaneous events still apply.
  - `pl_allocated` while the PL is not FREE: the grant is ignored and the state is unchanged.
  - `flit_sent` while the PL is FREE, or while it is DRAIN: the send is ignored, with no count change.
  - `flit_sent` with cnt = 0 and no `credit_in`: the send is ignored and the count holds at 0 (no underflow).
  - `credit_in` with cnt = `buf_len` and no valid send: the credit is ignored and the count holds at `buf_len` (no overflow).
- When `free_on_tail` = 1, a PL can be FREE with cnt < `buf_len`.
  - Re-allocation is legal in that case.
  - `credit_avail` gates sending.
  - Credits continue to return while the PL is FREE or ACTIVE.
- All np*nv lanes update in parallel. There is no cross-lane interaction.

## Timing

- Reset, effective at the first rising edge with `rst` = 1:
  - all states FREE
  - all counters = `buf_len`
  - `pl_alloc_status` all 1
  - `credit_avail` all 1
  - `error` = 0
- `rst` has priority over all other inputs. Asserting it mid-packet discards the lane's state and counts.
- All outputs are registered directly from state and counters, with no combinational path from inputs.
- `pl_allocated` sampled at edge k: `pl_alloc_status` is 0 from edge k onward. The allocator must not re-grant the lane on the cycle of the grant.
- Tail send at edge k with `free_on_tail` = 0: the state is DRAIN after k. The earliest FREE is after the edge at which the last outstanding credit arrives.
- With `free_on_tail` = 0, a PL cannot go ACTIVE -> FREE in one cycle. DRAIN lasts at least one cycle.
- Same-cycle credit that completes the drain: `pl_alloc_status` rises at that edge.
- An allocation in the cycle a lane becomes FREE is ignored and sets `error`, because status was still 0 when sampled.

## Test plan

- Reset, then idle 3 cycles: `pl_alloc_status` = all 1s, every `credit_count` = 4, `error` = 0.
- Port 1, PL 2, `buf_len` = 4, `free_on_tail` = 0:
  - Stimulus: grant at cycle 1; sends at cycles 2, 3, 4 with tail at 4; credits at cycles 6, 7, 8.
  - Response: status bit 6 goes low after cycle 1; count reaches 1 after cycle 4; DRAIN until cycle 8; status high after cycle 8.
- Same sequence with `free_on_tail` = 1: status high after cycle 4 while the count is still 1. A re-grant at cycle 5 is accepted with `error` = 0. Credits then return the count to 4.
- Send and credit in the same cycle with cnt = 2: the count stays 2. Send with cnt = 0: the count stays 0 and `error` = 1.
- Grant an ACTIVE lane, and return a credit at cnt = 4: `error` = 1, state unchanged, count stays 4. `error` stays 1 until `rst`.
- `rst` asserted while lane 0 is ACTIVE with count 1: after the edge, status = 1, count = 4, `error` = 0.
